// File: rtl/matrix_scan_driver_pkg.sv
// rtl/matrix_scan_driver_pkg.sv - shared geometry, scan states and row-slice helper for the LED matrix driver
package matrix_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int FRAME_W = 64;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Row r of a frame word occupies bits [8r+7:8r]; column c is bit 8r+c.
    function automatic logic [COLS-1:0] row_slice(input logic [FRAME_W-1:0] frame,
                                                  input logic [2:0]         row);
        return frame[{row, 3'b000} +: COLS];
    endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// rtl/matrix_scan_driver_if.sv - frame load and LED drive bundle (brightness present with MATRIX_BRIGHTNESS_EN)
interface matrix_scan_driver_if;
    import matrix_pkg::*;

    logic [FRAME_W-1:0] data;
    logic               load;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [3:0]         brightness;
`endif
    logic [ROWS-1:0]    LEDrow;
    logic [COLS-1:0]    LEDcol;
    logic               frame_start;

`ifdef MATRIX_BRIGHTNESS_EN
    modport master (output data, load, brightness, input LEDrow, LEDcol, frame_start);
    modport slave  (input data, load, brightness, output LEDrow, LEDcol, frame_start);
`else
    modport master (output data, load, input LEDrow, LEDcol, frame_start);
    modport slave  (input data, load, output LEDrow, LEDcol, frame_start);
`endif

endinterface

// File: rtl/matrix_scan_driver_row_dwell_timer.sv
// rtl/matrix_scan_driver_row_dwell_timer.sv - phase cycle counter with terminal-count done pulse
module row_dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] load_val,   // terminal count (phase length - 1)
    output logic [W-1:0] cnt,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign done = en && (cnt_q == load_val);

    // Count up while enabled; wrap to zero on the terminal cycle so the next phase starts at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered 8x8 row scan driver; MATRIX_BRIGHTNESS_EN adds per-frame dimming
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROW_DWELL    = 1350,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 pReset,
    matrix_scan_driver_if.slave  bus
);

    localparam int CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    scan_state_e        state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] pending_q, pending_d;
    logic               pending_valid_q, pending_valid_d;
    logic [ROWS-1:0]    led_row_q, led_row_d;
    logic [COLS-1:0]    led_col_q, led_col_d;
    logic               frame_start_q, frame_start_d;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [3:0]         bright_q, bright_d;
    logic [31:0]        on_cycles;
`endif

    logic [CNT_W-1:0]   cnt;
    logic               done;
    logic [CNT_W-1:0]   phase_last;
    logic               boundary;

    assign phase_last = (state_q == BLANK) ? CNT_W'(BLANK_CYCLES - 1) : CNT_W'(ROW_DWELL - 1);

    // One counter serves both phases; its terminal value follows the current state.
    row_dwell_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (pReset),
        .en       (1'b1),
        .load_val (phase_last),
        .cnt      (cnt),
        .done     (done)
    );

    // First BLANK cycle of row 0 is the only point where the displayed frame may change.
    assign boundary = (state_q == BLANK) && (row_q == 3'd0) && (cnt == '0);

    // Next-state, buffer management and registered-output values.
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        led_row_d       = '0;
        led_col_d       = '0;
        frame_start_d   = boundary;
`ifdef MATRIX_BRIGHTNESS_EN
        bright_d        = bright_q;
        on_cycles       = ((32'(bright_q) + 32'd1) * 32'(ROW_DWELL)) >> 4;
`endif

        case (state_q)
            BLANK: begin
                if (done) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                led_row_d = ROWS'(1) << row_q;
                led_col_d = row_slice(active_q, row_q);
`ifdef MATRIX_BRIGHTNESS_EN
                if (32'(cnt) >= on_cycles) begin
                    led_col_d = '0;
                end
`endif
                if (done) begin
                    state_d = BLANK;
                    row_d   = row_q + 3'd1;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase

        // Swap consumes the pending contents held before this cycle.
        if (boundary) begin
            if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end
`ifdef MATRIX_BRIGHTNESS_EN
            bright_d = bus.brightness;
`endif
        end

        // A load in the swap cycle lands for the following frame.
        if (bus.load) begin
            pending_d       = bus.data;
            pending_valid_d = 1'b1;
        end
    end

    // State, buffers and output registers; reset blanks the display and restarts the scan.
    always_ff @(posedge clk) begin
        if (pReset) begin
            state_q         <= BLANK;
            row_q           <= 3'd0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            led_row_q       <= '0;
            led_col_q       <= '0;
            frame_start_q   <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
            bright_q        <= 4'd0;
`endif
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            led_row_q       <= led_row_d;
            led_col_q       <= led_col_d;
            frame_start_q   <= frame_start_d;
`ifdef MATRIX_BRIGHTNESS_EN
            bright_q        <= bright_d;
`endif
        end
    end

    assign bus.LEDrow      = led_row_q;
    assign bus.LEDcol      = led_col_q;
    assign bus.frame_start = frame_start_q;

endmodule
